// File: rtl/color_buffer_pkg.sv
// color_buffer_pkg
//   Shared definitions for the color buffer: the controller state enum, the
//   RGBA channel lane positions inside a pixel, and the pixel and stream
//   width derivation used by color_buffer and color_buffer_ram.
//   A pixel is four SUB_PIXEL_WIDTH channels in RGBA order, with R in the
//   MSBs. A stream word holds two pixels, and the even pixel sits in the
//   low half.
package color_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam int NUM_CHANNELS = 4;

  // Lane index of each channel inside a pixel. Lane 0 holds the LSBs.
  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_G = 2;
  localparam int CH_R = 3;

  function automatic int pixel_width(input int sub_w);
    return NUM_CHANNELS * sub_w;
  endfunction

  function automatic int stream_width(input int sub_w);
    return 2 * pixel_width(sub_w);
  endfunction

  // Bit offset of a channel inside a pixel.
  function automatic int chan_offset(input int ch, input int sub_w);
    return ch * sub_w;
  endfunction

  // Map an RGBA-ordered mask (bit3=R ... bit0=A) onto per-lane enables.
  function automatic logic [NUM_CHANNELS-1:0] rgba_to_lanes(input logic [3:0] m);
    logic [NUM_CHANNELS-1:0] en;
    en       = '0;
    en[CH_R] = m[3];
    en[CH_G] = m[2];
    en[CH_B] = m[1];
    en[CH_A] = m[0];
    return en;
  endfunction

endpackage

// File: rtl/color_buffer_ram.sv
// color_buffer_ram
//   Dual-port, read-first RAM with per-lane byte enables. Each word holds
//   NUM_LANES lanes of LANE_WIDTH bits.
//   Port A is read-only. Port B is a read/write port.
//   Both read ports are registered, so read data appears one cycle after
//   the address is sampled. A write and a read of the same word on the
//   same edge return the old contents.
//   The storage itself is never reset. Only the read registers clear on
//   reset.
// Ports:
//   clk_i, rst_i           clock and async active-high reset (read regs only)
//   a_addr_i / a_rdata_o   port A read address / registered read data
//   b_addr_i               port B address (shared by read and write)
//   b_we_i, b_be_i         port B write strobe and per-lane enables
//   b_wdata_i / b_rdata_o  port B write data / registered read data
module color_buffer_ram #(
  parameter int ADDR_WIDTH = 13,
  parameter int LANE_WIDTH = 8,
  parameter int NUM_LANES  = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [ADDR_WIDTH-1:0]            a_addr_i,
  output logic [NUM_LANES*LANE_WIDTH-1:0]  a_rdata_o,
  input  logic [ADDR_WIDTH-1:0]            b_addr_i,
  input  logic                             b_we_i,
  input  logic [NUM_LANES-1:0]             b_be_i,
  input  logic [NUM_LANES*LANE_WIDTH-1:0]  b_wdata_i,
  output logic [NUM_LANES*LANE_WIDTH-1:0]  b_rdata_o
);

  localparam int DATA_WIDTH = NUM_LANES * LANE_WIDTH;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] a_rdata_q;
  logic [DATA_WIDTH-1:0] b_rdata_q;

  always_ff @(posedge clk_i) begin
    if (b_we_i) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (b_be_i[l]) begin
          mem_q[b_addr_i][l*LANE_WIDTH +: LANE_WIDTH] <= b_wdata_i[l*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Both reads sample the array before this edge's write lands (read-first).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= mem_q[a_addr_i];
      b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/color_buffer.sv
// color_buffer
//   Framebuffer color storage with three jobs:
//     - a pixel-pipeline read port with 1-cycle latency
//     - a pixel-pipeline write port, active only in IDLE
//     - two background operations, each started by a command pulse:
//         clear:  fill every pixel with a color
//         commit: stream the whole buffer out over AXI-Stream,
//                 two pixels per beat
//   The RAM stores two pixels per word (even pixel in the low half). This
//   lets a commit read one full beat per cycle from a single port.
//   Optional feature: COLOR_BUFFER_MASK_EN adds confColorMask[3:0], one
//   bit per RGBA channel (bit3=R). Pipeline writes and clear writes then
//   touch only the enabled channels. Without the macro, every write
//   updates all channels.
// Ports:
//   aclk, reset                       clock, async active-high reset
//   colorIndexRead / colorIn          pipeline read address / read data (+1 cycle)
//   colorIndexWrite, colorWriteEnable,
//   colorOut                          pipeline write port (IDLE only)
//   confClearColor                    clear value, sampled when a clear starts
//   cmdClear, cmdCommit               start pulses (clear wins if both)
//   busy                              high while a clear or commit runs
//   m_axis_tvalid/tready/tlast/tdata  commit stream
//   confColorMask                     channel write mask (COLOR_BUFFER_MASK_EN only)
module color_buffer
  import color_buffer_pkg::*;
#(
  parameter int FRAMEBUFFER_INDEX_WIDTH = 14,
  parameter int SUB_PIXEL_WIDTH         = 8,
  parameter int STREAM_WIDTH            = 64
) (
  input  logic                                      aclk,
  input  logic                                      reset,
  input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0]        colorIndexRead,
  output logic [pixel_width(SUB_PIXEL_WIDTH)-1:0]   colorIn,
  input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0]        colorIndexWrite,
  input  logic                                      colorWriteEnable,
  input  logic [pixel_width(SUB_PIXEL_WIDTH)-1:0]   colorOut,
  input  logic [pixel_width(SUB_PIXEL_WIDTH)-1:0]   confClearColor,
  input  logic                                      cmdClear,
  input  logic                                      cmdCommit,
  output logic                                      busy,
`ifdef COLOR_BUFFER_MASK_EN
  input  logic [3:0]                                confColorMask,
`endif
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic                                      m_axis_tlast,
  output logic [STREAM_WIDTH-1:0]                   m_axis_tdata
);

  localparam int PIXEL_WIDTH = pixel_width(SUB_PIXEL_WIDTH);
  localparam int IW          = FRAMEBUFFER_INDEX_WIDTH;
  localparam int WAW         = IW - 1;               // word address width
  localparam int NLANES      = 2 * NUM_CHANNELS;     // lanes per RAM word
  localparam logic [WAW-1:0] LAST_WORD  = {WAW{1'b1}};
  localparam logic [IW-1:0]  LAST_PIXEL = {IW{1'b1}};

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_e                  state_q;
  logic                    busy_q;
  logic [IW-1:0]           clr_idx_q;
  logic [PIXEL_WIDTH-1:0]  clear_color_q;
  logic [WAW-1:0]          rd_word_q;       // next commit word to read
  logic                    issue_done_q;    // every commit word has been read
  logic                    inflight_q;      // a RAM read lands this cycle
  logic                    inflight_last_q; // ...and it is the final word
  logic [STREAM_WIDTH-1:0] skid_data_q [2];
  logic [1:0]              skid_last_q;
  logic                    skid_wr_q;
  logic                    skid_rd_q;
  logic [1:0]              skid_cnt_q;
  logic                    rd_sel_q;        // odd pixel selected on port A

  // ---------------------------------------------------------------------
  // Channel write mask
  // ---------------------------------------------------------------------
  logic [NUM_CHANNELS-1:0] pix_en;
`ifdef COLOR_BUFFER_MASK_EN
  assign pix_en = rgba_to_lanes(confColorMask);
`else
  assign pix_en = rgba_to_lanes(4'b1111);
`endif

  // ---------------------------------------------------------------------
  // RAM port B: pipeline writes in IDLE, clear writes in CLEAR, commit
  // reads in COMMIT. A pixel index selects a word (upper bits) and a half
  // of that word (bit 0).
  // ---------------------------------------------------------------------
  logic [WAW-1:0]          b_addr;
  logic                    b_we;
  logic [NLANES-1:0]       b_be;
  logic [STREAM_WIDTH-1:0] b_wdata;
  logic [STREAM_WIDTH-1:0] b_rdata;
  logic [STREAM_WIDTH-1:0] a_rdata;

  always_comb begin
    b_addr  = rd_word_q;
    b_we    = 1'b0;
    b_be    = '0;
    b_wdata = {2{colorOut}};
    unique case (state_q)
      ST_IDLE: begin
        if (colorWriteEnable) begin
          b_we   = 1'b1;
          b_addr = colorIndexWrite[IW-1:1];
          b_be   = colorIndexWrite[0] ? {pix_en, {NUM_CHANNELS{1'b0}}}
                                      : {{NUM_CHANNELS{1'b0}}, pix_en};
        end
      end
      ST_CLEAR: begin
        b_we    = 1'b1;
        b_addr  = clr_idx_q[IW-1:1];
        b_wdata = {2{clear_color_q}};
        b_be    = clr_idx_q[0] ? {pix_en, {NUM_CHANNELS{1'b0}}}
                               : {{NUM_CHANNELS{1'b0}}, pix_en};
      end
      default: begin
        b_addr = rd_word_q;
      end
    endcase
  end

  color_buffer_ram #(
    .ADDR_WIDTH (WAW),
    .LANE_WIDTH (SUB_PIXEL_WIDTH),
    .NUM_LANES  (NLANES)
  ) u_ram (
    .clk_i     (aclk),
    .rst_i     (reset),
    .a_addr_i  (colorIndexRead[IW-1:1]),
    .a_rdata_o (a_rdata),
    .b_addr_i  (b_addr),
    .b_we_i    (b_we),
    .b_be_i    (b_be),
    .b_wdata_i (b_wdata),
    .b_rdata_o (b_rdata)
  );

  assign colorIn = rd_sel_q ? a_rdata[2*PIXEL_WIDTH-1:PIXEL_WIDTH]
                            : a_rdata[PIXEL_WIDTH-1:0];

  // ---------------------------------------------------------------------
  // Commit stream. Handshake: a beat transfers on an edge where tvalid and
  // tready are both high. While tvalid is high, tdata and tlast stay
  // unchanged until that transfer. tvalid never drops without a transfer.
  //
  // The two-entry skid register holds the beats. A RAM read costs one
  // cycle, so the next read is issued only when
  //   (entries held) + (reads in flight) - (beat leaving now)
  // stays below two. That keeps the skid register from ever overflowing
  // and still sustains one beat per cycle while tready is high.
  // ---------------------------------------------------------------------
  logic       tvalid;
  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occ;

  assign tvalid = (skid_cnt_q != 2'd0);
  assign pop    = tvalid && m_axis_tready;
  assign push   = inflight_q;
  assign occ    = {1'b0, skid_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue  = (state_q == ST_COMMIT) && !issue_done_q && (occ < 3'd2);

  assign m_axis_tvalid = tvalid;
  assign m_axis_tlast  = tvalid && skid_last_q[skid_rd_q];
  assign m_axis_tdata  = skid_data_q[skid_rd_q];
  assign busy          = busy_q;

  // ---------------------------------------------------------------------
  // Controller FSM plus skid bookkeeping
  // ---------------------------------------------------------------------
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      busy_q          <= 1'b0;
      clr_idx_q       <= '0;
      clear_color_q   <= '0;
      rd_word_q       <= '0;
      issue_done_q    <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      skid_data_q[0]  <= '0;
      skid_data_q[1]  <= '0;
      skid_last_q     <= '0;
      skid_wr_q       <= 1'b0;
      skid_rd_q       <= 1'b0;
      skid_cnt_q      <= '0;
      rd_sel_q        <= 1'b0;
    end else begin
      rd_sel_q        <= colorIndexRead[0];
      inflight_q      <= issue;
      inflight_last_q <= issue && (rd_word_q == LAST_WORD);

      if (push) begin
        skid_data_q[skid_wr_q] <= b_rdata;
        skid_last_q[skid_wr_q] <= inflight_last_q;
        skid_wr_q              <= ~skid_wr_q;
      end
      if (pop) begin
        skid_rd_q <= ~skid_rd_q;
      end
      skid_cnt_q <= skid_cnt_q + {1'b0, push} - {1'b0, pop};

      unique case (state_q)
        ST_IDLE: begin
          // A clear takes priority, so a commit in the same cycle is dropped.
          if (cmdClear) begin
            state_q       <= ST_CLEAR;
            busy_q        <= 1'b1;
            clr_idx_q     <= '0;
            clear_color_q <= confClearColor;
          end else if (cmdCommit) begin
            state_q      <= ST_COMMIT;
            busy_q       <= 1'b1;
            rd_word_q    <= '0;
            issue_done_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == LAST_PIXEL) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_COMMIT: begin
          if (issue) begin
            rd_word_q <= rd_word_q + 1'b1;
            if (rd_word_q == LAST_WORD) begin
              issue_done_q <= 1'b1;
            end
          end
          if (pop && skid_last_q[skid_rd_q]) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
